// File: rtl/el2_ic_mem_responder.sv
// Behavioural I-cache data/tag SRAM model with one-cycle read latency and a
// one-shot read-corruption port for exercising ECC/parity checkers.
module el2_ic_mem_responder #(
    parameter int  ICACHE_NUM_WAYS      = 2,
    parameter int  ICACHE_BANKS_WAY     = 2,
    parameter int  ICACHE_INDEX_HI      = 12,
    parameter int  ICACHE_DATA_INDEX_LO = 4,
    parameter int  ICACHE_TAG_INDEX_LO  = 6,
    localparam int WAY_BITS  = (ICACHE_NUM_WAYS  > 1) ? $clog2(ICACHE_NUM_WAYS)  : 1,
    localparam int BANK_BITS = (ICACHE_BANKS_WAY > 1) ? $clog2(ICACHE_BANKS_WAY) : 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [ICACHE_NUM_WAYS-1:0][ICACHE_BANKS_WAY-1:0]     ic_bank_way_clken_final_up,
    input  logic [ICACHE_BANKS_WAY-1:0][ICACHE_NUM_WAYS-1:0]     ic_b_sb_wren,
    input  logic [ICACHE_BANKS_WAY-1:0][71*ICACHE_NUM_WAYS-1:0]  ic_b_sb_bit_en_vec,
    input  logic [ICACHE_BANKS_WAY-1:0][70:0]                    ic_sb_wr_data,
    input  logic [ICACHE_BANKS_WAY-1:0][ICACHE_INDEX_HI:ICACHE_DATA_INDEX_LO] ic_rw_addr_bank_q,
    input  logic [ICACHE_BANKS_WAY-1:0]                          ic_tag_clken_final,
    input  logic [ICACHE_NUM_WAYS-1:0]                           ic_tag_wren_q,
    input  logic [26*ICACHE_NUM_WAYS-1:0]                        ic_tag_wren_biten_vec,
    input  logic [25:0]                                          ic_tag_wr_data,
    input  logic [ICACHE_INDEX_HI:ICACHE_TAG_INDEX_LO]            ic_rw_addr_q,
    output logic [ICACHE_NUM_WAYS-1:0][ICACHE_BANKS_WAY-1:0][70:0] wb_dout_pre_up,
    output logic [ICACHE_BANKS_WAY-1:0][71*ICACHE_NUM_WAYS-1:0]  wb_packeddout_pre,
    output logic [ICACHE_NUM_WAYS-1:0][25:0]                     ic_tag_data_raw_pre,
    output logic [26*ICACHE_NUM_WAYS-1:0]                        ic_tag_data_raw_packed_pre,
    input  logic                                                 inj_arm,
    input  logic                                                 inj_tag,
    input  logic [WAY_BITS-1:0]                                  inj_way,
    input  logic [BANK_BITS-1:0]                                 inj_bank,
    input  logic [70:0]                                          inj_mask,
    output logic                                                 inj_pending,
    output logic                                                 inj_done
);

    localparam int DATA_DEPTH = 1 << (ICACHE_INDEX_HI - ICACHE_DATA_INDEX_LO + 1);
    localparam int TAG_DEPTH  = 1 << (ICACHE_INDEX_HI - ICACHE_TAG_INDEX_LO + 1);

    typedef enum logic {INJ_IDLE, INJ_ARMED} inj_state_t;

    inj_state_t             state_q, state_d;
    logic                   inj_tag_q;
    logic [WAY_BITS-1:0]    inj_way_q;
    logic [BANK_BITS-1:0]   inj_bank_q;
    logic [70:0]            inj_mask_q;
    logic                   inj_hit;
    logic                   target_rd;
    logic [ICACHE_NUM_WAYS-1:0][ICACHE_BANKS_WAY-1:0] data_rd;
    logic [ICACHE_NUM_WAYS-1:0]                       tag_rd;

    always_comb begin
        data_rd = '0;
        for (int unsigned w = 0; w < ICACHE_NUM_WAYS; w++)
            for (int unsigned b = 0; b < ICACHE_BANKS_WAY; b++)
                data_rd[w][b] = ic_bank_way_clken_final_up[w][b] & ~ic_b_sb_wren[b][w];
    end

    assign tag_rd    = {ICACHE_NUM_WAYS{|ic_tag_clken_final}} & ~ic_tag_wren_q;
    assign target_rd = inj_tag_q ? tag_rd[inj_way_q] : data_rd[inj_way_q][inj_bank_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INJ_IDLE;
            inj_tag_q  <= 1'b0;
            inj_way_q  <= '0;
            inj_bank_q <= '0;
            inj_mask_q <= '0;
            inj_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            inj_done <= inj_hit;
            if (inj_arm) begin
                inj_tag_q  <= inj_tag;
                inj_way_q  <= inj_way;
                inj_bank_q <= inj_bank;
                inj_mask_q <= inj_mask;
            end
        end
    end

    // An arm in the same cycle discards any older request, so it suppresses the hit.
    always_comb begin
        state_d = state_q;
        inj_hit = 1'b0;
        if (inj_arm) begin
            state_d = INJ_ARMED;
        end else if (state_q == INJ_ARMED && target_rd) begin
            state_d = INJ_IDLE;
            inj_hit = 1'b1;
        end
    end

    assign inj_pending = (state_q == INJ_ARMED);

    for (genvar w = 0; w < ICACHE_NUM_WAYS; w++) begin : g_way
        localparam logic [WAY_BITS-1:0] WAY_ID = WAY_BITS'(w);

        for (genvar b = 0; b < ICACHE_BANKS_WAY; b++) begin : g_bank
            localparam logic [BANK_BITS-1:0] BANK_ID = BANK_BITS'(b);

            logic [70:0] mem [DATA_DEPTH] = '{default: '0};
            logic [70:0] dout_q;
            logic [70:0] be;
            logic [ICACHE_INDEX_HI-ICACHE_DATA_INDEX_LO:0] addr;
            logic        hit_here;

            assign addr     = ic_rw_addr_bank_q[b];
            assign be       = ic_b_sb_bit_en_vec[b][71*w +: 71];
            assign hit_here = inj_hit & ~inj_tag_q & (inj_way_q == WAY_ID) & (inj_bank_q == BANK_ID);

            always_ff @(posedge clk) begin
                if (ic_bank_way_clken_final_up[w][b] && ic_b_sb_wren[b][w])
                    mem[addr] <= (mem[addr] & ~be) | (ic_sb_wr_data[b] & be);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    dout_q <= '0;
                else if (data_rd[w][b])
                    dout_q <= mem[addr] ^ (hit_here ? inj_mask_q : '0);
            end

            assign wb_dout_pre_up[w][b]            = dout_q;
            assign wb_packeddout_pre[b][71*w +: 71] = dout_q;
        end

        logic [25:0] tmem [TAG_DEPTH] = '{default: '0};
        logic [25:0] tag_q;
        logic [25:0] tbe;
        logic        tag_hit;

        assign tbe     = ic_tag_wren_biten_vec[26*w +: 26];
        assign tag_hit = inj_hit & inj_tag_q & (inj_way_q == WAY_ID);

        always_ff @(posedge clk) begin
            if ((|ic_tag_clken_final) && ic_tag_wren_q[w])
                tmem[ic_rw_addr_q] <= (tmem[ic_rw_addr_q] & ~tbe) | (ic_tag_wr_data & tbe);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                tag_q <= '0;
            else if (tag_rd[w])
                tag_q <= tmem[ic_rw_addr_q] ^ (tag_hit ? inj_mask_q[25:0] : '0);
        end

        assign ic_tag_data_raw_pre[w]               = tag_q;
        assign ic_tag_data_raw_packed_pre[26*w +: 26] = tag_q;
    end

endmodule

// File: tb/tb_el2_ic_mem_responder.sv
// Directed self-checking bench for el2_ic_mem_responder (2 ways x 2 banks).
module tb_el2_ic_mem_responder;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [1:0][1:0]        clken;
    logic [1:0][1:0]        wren;
    logic [1:0][141:0]      bev;
    logic [1:0][70:0]       wd;
    logic [1:0][12:4]       baddr;
    logic [1:0]             tclken;
    logic [1:0]             twren;
    logic [51:0]            tbev;
    logic [25:0]            twd;
    logic [12:6]            taddr;
    logic [1:0][1:0][70:0]  dout;
    logic [1:0][141:0]      pdout;
    logic [1:0][25:0]       tag;
    logic [51:0]            ptag;
    logic                   inj_arm;
    logic                   inj_tag;
    logic [0:0]             inj_way;
    logic [0:0]             inj_bank;
    logic [70:0]            inj_mask;
    logic                   inj_pending;
    logic                   inj_done;

    localparam logic [70:0] D5A  = 71'h5A5A5A5A5A5A5A5A5A;
    localparam logic [70:0] ONES = '1;
    localparam logic [70:0] D12  = 71'h1234;
    localparam logic [25:0] TAGV = 26'h2ABCDEF;

    int unsigned total = 0;
    int unsigned bad   = 0;

    el2_ic_mem_responder dut (
        .clk                        (clk),
        .rst                        (rst),
        .ic_bank_way_clken_final_up (clken),
        .ic_b_sb_wren               (wren),
        .ic_b_sb_bit_en_vec         (bev),
        .ic_sb_wr_data              (wd),
        .ic_rw_addr_bank_q          (baddr),
        .ic_tag_clken_final         (tclken),
        .ic_tag_wren_q              (twren),
        .ic_tag_wren_biten_vec      (tbev),
        .ic_tag_wr_data             (twd),
        .ic_rw_addr_q               (taddr),
        .wb_dout_pre_up             (dout),
        .wb_packeddout_pre          (pdout),
        .ic_tag_data_raw_pre        (tag),
        .ic_tag_data_raw_packed_pre (ptag),
        .inj_arm                    (inj_arm),
        .inj_tag                    (inj_tag),
        .inj_way                    (inj_way),
        .inj_bank                   (inj_bank),
        .inj_mask                   (inj_mask),
        .inj_pending                (inj_pending),
        .inj_done                   (inj_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [287:0] got, input logic [287:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clken   = '0;
        wren    = '0;
        bev     = '0;
        wd      = '0;
        tclken  = '0;
        twren   = '0;
        tbev    = '0;
        twd     = '0;
        inj_arm = 1'b0;
    endtask

    task automatic data_wr(input int w, input int b, input logic [8:0] a,
                           input logic [70:0] d, input logic [70:0] be);
        clken[w][b]        = 1'b1;
        wren[b][w]         = 1'b1;
        bev[b][71*w +: 71] = be;
        wd[b]              = d;
        baddr[b]           = a;
        tick();
        idle();
    endtask

    task automatic data_rd(input int w, input int b, input logic [8:0] a);
        clken[w][b] = 1'b1;
        baddr[b]    = a;
        tick();
        idle();
    endtask

    task automatic arm(input logic t, input logic w, input logic b, input logic [70:0] m);
        inj_arm  = 1'b1;
        inj_tag  = t;
        inj_way  = w;
        inj_bank = b;
        inj_mask = m;
        tick();
        idle();
    endtask

    initial begin
        idle();
        baddr    = '0;
        taddr    = '0;
        inj_tag  = 1'b0;
        inj_way  = '0;
        inj_bank = '0;
        inj_mask = '0;

        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_dout", 288'(dout), '0);
        check("rst_tag", 288'(tag), '0);
        check("rst_pending", 288'(inj_pending), '0);
        check("rst_done", 288'(inj_done), '0);
        rst = 1'b0;
        tick();

        // Full write then read, unpacked and packed views
        data_wr(1, 0, 9'h1F3, D5A, ONES);
        check("wr_holds_out", 288'(dout[1][0]), '0);
        data_rd(1, 0, 9'h1F3);
        check("rd_w1b0", 288'(dout[1][0]), 288'(D5A));
        check("rd_w1b0_packed", 288'(pdout[0][141:71]), 288'(D5A));

        // Partial write to way0 at the same row; way1 content must be untouched
        data_wr(0, 0, 9'h1F3, ONES, 71'hFF);
        clken[0][0] = 1'b1;
        clken[1][0] = 1'b1;
        baddr[0]    = 9'h1F3;
        tick();
        idle();
        check("partial_w0b0", 288'(dout[0][0]), 288'(71'hFF));
        check("partial_w1b0", 288'(dout[1][0]), 288'(D5A));
        check("partial_packed", 288'(pdout[0]), 288'({D5A, 71'hFF}));

        // Zero bit-enable write changes nothing
        data_wr(0, 0, 9'h1F3, ONES, '0);
        check("zbe_holds_out", 288'(dout[0][0]), 288'(71'hFF));
        data_rd(0, 0, 9'h1F3);
        check("zbe_rd", 288'(dout[0][0]), 288'(71'hFF));

        // Enables low with address toggling: outputs hold
        for (int i = 0; i < 10; i++) begin
            baddr[0] = 9'($urandom);
            baddr[1] = 9'($urandom);
            tick();
            check("hold_w0b0", 288'(dout[0][0]), 288'(71'hFF));
            check("hold_w1b0", 288'(dout[1][0]), 288'(D5A));
        end

        // Tag write way0 row 0x7F, then read both ways
        tclken = 2'b01;
        twren  = 2'b01;
        tbev   = {26'h0, 26'h3FFFFFF};
        twd    = TAGV;
        taddr  = 7'h7F;
        tick();
        idle();
        check("tag_wr_holds", 288'(tag[0]), '0);
        tclken = 2'b10;
        tick();
        idle();
        check("tag_rd_w0", 288'(tag[0]), 288'(TAGV));
        check("tag_rd_w1", 288'(tag[1]), '0);
        check("tag_packed", 288'(ptag), 288'({26'h0, TAGV}));

        // Data injection: way0/bank1, mask bit 3
        data_wr(0, 1, 9'h010, D12, ONES);
        arm(1'b0, 1'b0, 1'b1, 71'h8);
        check("inj_armed", 288'(inj_pending), 288'(1'b1));
        data_rd(1, 1, 9'h010);
        check("inj_other_rd", 288'(dout[1][1]), '0);
        check("inj_other_pend", 288'(inj_pending), 288'(1'b1));
        check("inj_other_done", 288'(inj_done), '0);
        data_rd(0, 1, 9'h010);
        check("inj_rd1", 288'(dout[0][1]), 288'(71'h123C));
        check("inj_rd1_done", 288'(inj_done), 288'(1'b1));
        check("inj_rd1_pend", 288'(inj_pending), '0);
        data_rd(0, 1, 9'h010);
        check("inj_rd2", 288'(dout[0][1]), 288'(D12));
        check("inj_rd2_done", 288'(inj_done), '0);

        // Arm concurrent with a target read: that read stays clean
        inj_arm     = 1'b1;
        inj_tag     = 1'b0;
        inj_way     = 1'b0;
        inj_bank    = 1'b1;
        inj_mask    = 71'h8;
        clken[0][1] = 1'b1;
        baddr[1]    = 9'h010;
        tick();
        idle();
        check("same_cyc_rd", 288'(dout[0][1]), 288'(D12));
        check("same_cyc_pend", 288'(inj_pending), 288'(1'b1));
        check("same_cyc_done", 288'(inj_done), '0);
        data_rd(0, 1, 9'h010);
        check("same_cyc_next", 288'(dout[0][1]), 288'(71'h123C));
        check("same_cyc_ndone", 288'(inj_done), 288'(1'b1));

        // Re-arm replaces the earlier target
        arm(1'b0, 1'b0, 1'b1, 71'h8);
        arm(1'b0, 1'b1, 1'b1, 71'h100);
        data_rd(0, 1, 9'h010);
        check("rearm_old", 288'(dout[0][1]), 288'(D12));
        check("rearm_pend", 288'(inj_pending), 288'(1'b1));
        data_rd(1, 1, 9'h010);
        check("rearm_new", 288'(dout[1][1]), 288'(71'h100));
        check("rearm_done", 288'(inj_done), 288'(1'b1));

        // Tag injection on way1 only
        arm(1'b1, 1'b1, 1'b1, 71'h1);
        tclken = 2'b11;
        taddr  = 7'h7F;
        tick();
        idle();
        check("tinj_packed", 288'(ptag), 288'({26'h1, TAGV}));
        check("tinj_done", 288'(inj_done), 288'(1'b1));
        check("tinj_pend", 288'(inj_pending), '0);

        // Asynchronous reset while pending, after a read
        arm(1'b0, 1'b0, 1'b1, 71'h8);
        data_rd(1, 0, 9'h1F3);
        check("prerst_rd", 288'(dout[1][0]), 288'(D5A));
        #2 rst = 1'b1;
        #1;
        check("arst_dout", 288'(dout), '0);
        check("arst_pdout", 288'(pdout), '0);
        check("arst_tag", 288'(ptag), '0);
        check("arst_pend", 288'(inj_pending), '0);
        tick();
        rst = 1'b0;
        data_rd(0, 1, 9'h010);
        check("postrst_rd", 288'(dout[0][1]), 288'(D12));
        check("postrst_done", 288'(inj_done), '0);
        data_rd(1, 0, 9'h1F3);
        check("postrst_keep", 288'(dout[1][0]), 288'(D5A));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
